// File: rtl/bus_arbiter_if.sv
// Bundle of the two master handshakes, the shared bus and the grant vector
// for bus_arbiter. The slave view is what the arbiter sees; the master view
// is the surrounding environment (core, DMA loader, Bridge).
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Master 0: CPU load/store port
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  // Master 1: DMA / debug loader
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  // Shared Bridge bus
  logic [ADDR_W-1:0] Bus_addr;
  logic              Bus_wen;
  logic [DATA_W-1:0] Bus_wdata;
  logic [DATA_W-1:0] Bus_rdata;

  // One-hot current owner
  logic [1:0]        gnt;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output Bus_addr, Bus_wen, Bus_wdata,
    input  Bus_rdata,
    output gnt
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  Bus_addr, Bus_wen, Bus_wdata,
    output Bus_rdata,
    input  gnt
  );

endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the Bridge data bus.
// A granted transaction owns the bus for LAT access cycles followed by one
// DONE cycle carrying the ack pulse, so back-to-back service takes LAT+2
// cycles. Master fields are captured only on the grant edge.
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  bus_arbiter_if.slave  bus
);

  // Reject an out-of-range access latency at elaboration time
  generate
    if (LAT < 1 || LAT > 15) begin : g_bad_lat
      $error("bus_arbiter: LAT must be in the range 1..15");
    end
  endgenerate

  // The counter counts down the remaining access cycles after the first one
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // State register; reset aborts any transaction and makes m0 win first
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, count out the access, then ack
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          if (bus.m0_req && bus.m1_req) begin
            owner_d = ~last_q;
          end else begin
            owner_d = bus.m1_req;
          end
          if (owner_d) begin
            we_d    = bus.m1_we;
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
          end else begin
            we_d    = bus.m0_we;
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
          end
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q) begin
              rdata1_d = bus.Bus_rdata;
            end else begin
              rdata0_d = bus.Bus_rdata;
            end
          end
          state_d = DONE;
        end
      end

      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode purely from registers: bus driven only during ACCESS,
  // single write strobe on the final access cycle, ack only in DONE
  always_comb begin
    bus.Bus_addr  = '0;
    bus.Bus_wdata = '0;
    bus.Bus_wen   = 1'b0;
    bus.m0_ack    = 1'b0;
    bus.m1_ack    = 1'b0;
    bus.gnt       = 2'b00;

    if (state_q == ACCESS) begin
      bus.Bus_addr  = addr_q;
      bus.Bus_wdata = wdata_q;
      bus.Bus_wen   = we_q && (cnt_q == 4'd0);
    end

    if (state_q == DONE) begin
      bus.m0_ack = ~owner_q;
      bus.m1_ack = owner_q;
    end

    if (state_q != IDLE) begin
      bus.gnt = owner_q ? 2'b10 : 2'b01;
    end

    bus.m0_rdata = rdata0_q;
    bus.m1_rdata = rdata1_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Four instances with LAT=1..4 share a
// clock and reset; each scenario task drives one instance and checks the
// hand-computed cycle-by-cycle response.
module tb_bus_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc1 ();
  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc2 ();
  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc3 ();
  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc4 ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u1 (.cpu_clk(clk), .cpu_rst(rst), .bus(ifc1));
  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2)) u2 (.cpu_clk(clk), .cpu_rst(rst), .bus(ifc2));
  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3)) u3 (.cpu_clk(clk), .cpu_rst(rst), .bus(ifc3));
  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(4)) u4 (.cpu_clk(clk), .cpu_rst(rst), .bus(ifc4));

  // Free-running 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    vectors++;
    if ({ifc1.gnt, ifc1.m0_ack, ifc1.m1_ack, ifc1.Bus_wen, ifc1.Bus_addr, ifc1.Bus_wdata, ifc1.m0_rdata, ifc1.m1_rdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_u1: got gnt=%b wen=%b addr=%h", ifc1.gnt, ifc1.Bus_wen, ifc1.Bus_addr);
    end
    vectors++;
    if ({ifc2.gnt, ifc2.m0_ack, ifc2.m1_ack, ifc2.Bus_wen, ifc2.Bus_addr, ifc2.Bus_wdata, ifc2.m0_rdata, ifc2.m1_rdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_u2: got gnt=%b wen=%b addr=%h", ifc2.gnt, ifc2.Bus_wen, ifc2.Bus_addr);
    end
    vectors++;
    if ({ifc3.gnt, ifc3.m0_ack, ifc3.m1_ack, ifc3.Bus_wen, ifc3.Bus_addr, ifc3.Bus_wdata, ifc3.m0_rdata, ifc3.m1_rdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_u3: got gnt=%b wen=%b addr=%h", ifc3.gnt, ifc3.Bus_wen, ifc3.Bus_addr);
    end
    vectors++;
    if ({ifc4.gnt, ifc4.m0_ack, ifc4.m1_ack, ifc4.Bus_wen, ifc4.Bus_addr, ifc4.Bus_wdata, ifc4.m0_rdata, ifc4.m1_rdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_u4: got gnt=%b wen=%b addr=%h", ifc4.gnt, ifc4.Bus_wen, ifc4.Bus_addr);
    end
    tick();
    rst = 1'b0;
  endtask

  // LAT=2 read by m0
  task automatic test_read_lat2;
    ifc2.m0_we     = 1'b0;
    ifc2.m0_addr   = 32'h0000_1000;
    ifc2.Bus_rdata = 32'hDEAD_BEEF;
    ifc2.m0_req    = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      vectors++;
      if ({ifc2.gnt, ifc2.Bus_wen, ifc2.m0_ack, ifc2.Bus_addr} !== {2'b01, 1'b0, 1'b0, 32'h0000_1000}) begin
        miscompares++;
        $display("[TB] FAIL read_access_c%0d: got gnt=%b wen=%b ack=%b addr=%h, want 01 0 0 00001000", c, ifc2.gnt, ifc2.Bus_wen, ifc2.m0_ack, ifc2.Bus_addr);
      end
    end
    tick();
    vectors++;
    if ({ifc2.m0_ack, ifc2.m1_ack, ifc2.gnt, ifc2.Bus_wen, ifc2.Bus_addr, ifc2.m0_rdata} !== {1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("[TB] FAIL read_ack: got ack=%b gnt=%b wen=%b addr=%h rdata=%h, want 1 01 0 0 deadbeef", ifc2.m0_ack, ifc2.gnt, ifc2.Bus_wen, ifc2.Bus_addr, ifc2.m0_rdata);
    end
    ifc2.m0_req = 1'b0;
    tick();
    vectors++;
    if ({ifc2.m0_ack, ifc2.gnt, ifc2.m0_rdata} !== {1'b0, 2'b00, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("[TB] FAIL read_idle: got ack=%b gnt=%b rdata=%h, want 0 00 deadbeef", ifc2.m0_ack, ifc2.gnt, ifc2.m0_rdata);
    end
  endtask

  // LAT=3 write by m1: one strobe on the last access cycle, rdata untouched
  task automatic test_write_lat3;
    ifc3.Bus_rdata = 32'hAAAA_5555;
    ifc3.m1_we     = 1'b1;
    ifc3.m1_addr   = 32'hFFFF_F000;
    ifc3.m1_wdata  = 32'h1234_5678;
    ifc3.m1_req    = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vectors++;
      if ({ifc3.gnt, ifc3.Bus_wen, ifc3.Bus_addr, ifc3.Bus_wdata} !== {2'b10, (c == 3), 32'hFFFF_F000, 32'h1234_5678}) begin
        miscompares++;
        $display("[TB] FAIL write_access_c%0d: got gnt=%b wen=%b addr=%h wdata=%h", c, ifc3.gnt, ifc3.Bus_wen, ifc3.Bus_addr, ifc3.Bus_wdata);
      end
    end
    tick();
    vectors++;
    if ({ifc3.m1_ack, ifc3.m0_ack, ifc3.Bus_wen, ifc3.gnt, ifc3.m1_rdata} !== {1'b1, 1'b0, 1'b0, 2'b10, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL write_ack: got m1_ack=%b m0_ack=%b wen=%b gnt=%b m1_rdata=%h, want 1 0 0 10 0", ifc3.m1_ack, ifc3.m0_ack, ifc3.Bus_wen, ifc3.gnt, ifc3.m1_rdata);
    end
    ifc3.m1_req = 1'b0;
    tick();
    vectors++;
    if ({ifc3.m1_ack, ifc3.gnt, ifc3.Bus_wen, ifc3.m1_rdata} !== {1'b0, 2'b00, 1'b0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL write_idle: got ack=%b gnt=%b wen=%b rdata=%h", ifc3.m1_ack, ifc3.gnt, ifc3.Bus_wen, ifc3.m1_rdata);
    end
  endtask

  // Continuous contention on LAT=2 after reset: m0, m1, m0
  task automatic test_round_robin;
    logic       own;
    logic [1:0] expGnt;
    logic [1:0] expAck;
    logic [31:0] expAddr;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc2.m0_we     = 1'b0;
    ifc2.m1_we     = 1'b0;
    ifc2.m0_addr   = 32'h0000_0100;
    ifc2.m1_addr   = 32'h0000_0200;
    ifc2.Bus_rdata = 32'h0BAD_F00D;
    ifc2.m0_req    = 1'b1;
    ifc2.m1_req    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      own     = (k == 1);
      expGnt  = own ? 2'b10 : 2'b01;
      expAck  = own ? 2'b01 : 2'b10;
      expAddr = own ? 32'h0000_0200 : 32'h0000_0100;
      tick();
      vectors++;
      if ({ifc2.gnt, ifc2.Bus_addr} !== {expGnt, expAddr}) begin
        miscompares++;
        $display("[TB] FAIL rr_grant_%0d: got gnt=%b addr=%h, want %b %h", k, ifc2.gnt, ifc2.Bus_addr, expGnt, expAddr);
      end
      tick();
      tick();
      vectors++;
      if ({ifc2.m0_ack, ifc2.m1_ack, ifc2.gnt} !== {expAck, expGnt}) begin
        miscompares++;
        $display("[TB] FAIL rr_ack_%0d: got acks=%b%b gnt=%b, want %b %b", k, ifc2.m0_ack, ifc2.m1_ack, ifc2.gnt, expAck, expGnt);
      end
      if (k == 2) begin
        ifc2.m0_req = 1'b0;
        ifc2.m1_req = 1'b0;
      end
      tick();
      vectors++;
      if ({ifc2.m0_ack, ifc2.m1_ack, ifc2.gnt} !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL rr_idle_%0d: got acks=%b%b gnt=%b, want 00 00", k, ifc2.m0_ack, ifc2.m1_ack, ifc2.gnt);
      end
    end
  endtask

  // LAT=1: m0 drops req right after the grant, transaction still completes
  task automatic test_drop_lat1;
    ifc1.m0_we     = 1'b0;
    ifc1.m0_addr   = 32'h0000_0040;
    ifc1.Bus_rdata = 32'hCAFE_0001;
    ifc1.m0_req    = 1'b1;
    tick();
    vectors++;
    if ({ifc1.gnt, ifc1.Bus_addr} !== {2'b01, 32'h0000_0040}) begin
      miscompares++;
      $display("[TB] FAIL drop_grant: got gnt=%b addr=%h, want 01 00000040", ifc1.gnt, ifc1.Bus_addr);
    end
    ifc1.m0_req  = 1'b0;
    ifc1.m0_addr = 32'h0000_0999;
    tick();
    vectors++;
    if ({ifc1.m0_ack, ifc1.gnt, ifc1.m0_rdata} !== {1'b1, 2'b01, 32'hCAFE_0001}) begin
      miscompares++;
      $display("[TB] FAIL drop_ack: got ack=%b gnt=%b rdata=%h, want 1 01 cafe0001", ifc1.m0_ack, ifc1.gnt, ifc1.m0_rdata);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({ifc1.m0_ack, ifc1.gnt, ifc1.Bus_addr} !== {1'b0, 2'b00, 32'h0}) begin
        miscompares++;
        $display("[TB] FAIL drop_idle_%0d: got ack=%b gnt=%b addr=%h, want 0 00 0", c, ifc1.m0_ack, ifc1.gnt, ifc1.Bus_addr);
      end
    end
  endtask

  // LAT=2: m0 keeps req high across its ack, yielding a second read
  task automatic test_back_to_back;
    ifc2.m0_we     = 1'b0;
    ifc2.m0_addr   = 32'h0000_0500;
    ifc2.Bus_rdata = 32'h0000_0011;
    ifc2.m0_req    = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if ({ifc2.m0_ack, ifc2.m0_rdata} !== {1'b1, 32'h0000_0011}) begin
      miscompares++;
      $display("[TB] FAIL b2b_ack1: got ack=%b rdata=%h, want 1 00000011", ifc2.m0_ack, ifc2.m0_rdata);
    end
    ifc2.Bus_rdata = 32'h0000_0022;
    tick();
    vectors++;
    if ({ifc2.m0_ack, ifc2.gnt, ifc2.m0_rdata} !== {1'b0, 2'b00, 32'h0000_0011}) begin
      miscompares++;
      $display("[TB] FAIL b2b_gap: got ack=%b gnt=%b rdata=%h, want 0 00 00000011", ifc2.m0_ack, ifc2.gnt, ifc2.m0_rdata);
    end
    tick();
    vectors++;
    if ({ifc2.gnt, ifc2.m0_ack} !== {2'b01, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL b2b_regrant: got gnt=%b ack=%b, want 01 0", ifc2.gnt, ifc2.m0_ack);
    end
    tick();
    tick();
    vectors++;
    if ({ifc2.m0_ack, ifc2.m0_rdata} !== {1'b1, 32'h0000_0022}) begin
      miscompares++;
      $display("[TB] FAIL b2b_ack2: got ack=%b rdata=%h, want 1 00000022", ifc2.m0_ack, ifc2.m0_rdata);
    end
    ifc2.m0_req = 1'b0;
    tick();
  endtask

  // LAT=4: reset lands during the write strobe, then a fresh m1 read
  task automatic test_reset_mid;
    ifc4.m0_we    = 1'b1;
    ifc4.m0_addr  = 32'h0000_0080;
    ifc4.m0_wdata = 32'h0000_0055;
    ifc4.m0_req   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++;
      if ({ifc4.gnt, ifc4.Bus_wen, ifc4.Bus_addr} !== {2'b01, (c == 4), 32'h0000_0080}) begin
        miscompares++;
        $display("[TB] FAIL rstmid_access_c%0d: got gnt=%b wen=%b addr=%h", c, ifc4.gnt, ifc4.Bus_wen, ifc4.Bus_addr);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({ifc4.gnt, ifc4.Bus_wen, ifc4.Bus_addr, ifc4.Bus_wdata, ifc4.m0_ack, ifc4.m1_ack} !== '0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_outputs: got gnt=%b wen=%b addr=%h wdata=%h ack=%b, want all 0", ifc4.gnt, ifc4.Bus_wen, ifc4.Bus_addr, ifc4.Bus_wdata, ifc4.m0_ack);
    end
    vectors++;
    if ({ifc2.m0_rdata, ifc2.m1_rdata, ifc1.m0_rdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_rdata: got u2 m0=%h m1=%h u1 m0=%h, want 0", ifc2.m0_rdata, ifc2.m1_rdata, ifc1.m0_rdata);
    end
    ifc4.m0_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({ifc4.m0_ack, ifc4.gnt} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL rstmid_noack: got ack=%b gnt=%b, want 0 00", ifc4.m0_ack, ifc4.gnt);
    end
    ifc4.m1_we     = 1'b0;
    ifc4.m1_addr   = 32'h0000_3000;
    ifc4.Bus_rdata = 32'h0000_0077;
    ifc4.m1_req    = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++;
      if ({ifc4.gnt, ifc4.Bus_addr, ifc4.m1_ack, ifc4.Bus_wen} !== {2'b10, 32'h0000_3000, 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL rstmid_fresh_c%0d: got gnt=%b addr=%h ack=%b wen=%b", c, ifc4.gnt, ifc4.Bus_addr, ifc4.m1_ack, ifc4.Bus_wen);
      end
    end
    tick();
    vectors++;
    if ({ifc4.m1_ack, ifc4.m0_ack, ifc4.m1_rdata} !== {1'b1, 1'b0, 32'h0000_0077}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_fresh_ack: got m1_ack=%b m0_ack=%b rdata=%h, want 1 0 00000077", ifc4.m1_ack, ifc4.m0_ack, ifc4.m1_rdata);
    end
    ifc4.m1_req = 1'b0;
    tick();
  endtask

  // Scenario sequencer
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    {ifc1.m0_req, ifc1.m0_we, ifc1.m0_addr, ifc1.m0_wdata, ifc1.m1_req, ifc1.m1_we, ifc1.m1_addr, ifc1.m1_wdata, ifc1.Bus_rdata} = '0;
    {ifc2.m0_req, ifc2.m0_we, ifc2.m0_addr, ifc2.m0_wdata, ifc2.m1_req, ifc2.m1_we, ifc2.m1_addr, ifc2.m1_wdata, ifc2.Bus_rdata} = '0;
    {ifc3.m0_req, ifc3.m0_we, ifc3.m0_addr, ifc3.m0_wdata, ifc3.m1_req, ifc3.m1_we, ifc3.m1_addr, ifc3.m1_wdata, ifc3.Bus_rdata} = '0;
    {ifc4.m0_req, ifc4.m0_we, ifc4.m0_addr, ifc4.m0_wdata, ifc4.m1_req, ifc4.m1_we, ifc4.m1_addr, ifc4.m1_wdata, ifc4.Bus_rdata} = '0;

    test_reset();
    test_read_lat2();
    test_write_lat3();
    test_round_robin();
    test_drop_lat1();
    test_back_to_back();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
